// File: rtl/apb_completer_regfile.sv
// APB completer with a small register file, read-only ID at address 0 and fixed wait states.
// Out-of-range accesses and writes to the ID register complete with pslverr.
module apb_completer_regfile #(
    parameter int unsigned DEPTH       = 12,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
    input  logic       pclk_i,
    input  logic       preset_i,
    input  logic       psel_i,
    input  logic       penable_i,
    input  logic       pwrite_i,
    input  logic [3:0] paddr_i,
    input  logic [7:0] pwdata_i,
    output logic [7:0] prdata_o,
    output logic       pready_o,
    output logic       pslverr_o
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [4:0] DepthW   = 5'(DEPTH);
    localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

    state_e     state_q, state_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] prdata_q, prdata_d;
    logic       pready_q, pready_d;
    logic       pslverr_q, pslverr_d;
    logic       mem_we;
    logic       oor;
    logic       err;

    // Address 0 is the ID register, so storage only covers 1..DEPTH-1.
    logic [7:0] mem_q [1:DEPTH-1];

    assign oor = ({1'b0, addr_q} >= DepthW);
    assign err = oor || (write_q && (addr_q == 4'd0));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        mem_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    cnt_d   = WaitInit;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!psel_i) begin
                    state_d = StIdle;
                end else if (penable_i) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        pready_d  = 1'b1;
                        pslverr_d = err;
                        mem_we    = write_q && !err;
                        if (!write_q) begin
                            if (addr_q == 4'd0) begin
                                prdata_d = ID_VALUE;
                            end else if (oor) begin
                                prdata_d = 8'h00;
                            end else begin
                                prdata_d = mem_q[addr_q];
                            end
                        end
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q   <= StIdle;
            addr_q    <= 4'd0;
            cnt_q     <= 4'd0;
            write_q   <= 1'b0;
            wdata_q   <= 8'h00;
            prdata_q  <= 8'h00;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            mem_q     <= '{default: 8'h00};
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            if (mem_we) begin
                mem_q[addr_q] <= wdata_q;
            end
        end
    end

    assign prdata_o  = prdata_q;
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed and random APB transfers on a default and a zero-wait-state completer,
// checked against an array model of the register file and the transfer timing rules.
module tb_apb_completer_regfile;

    localparam int Depth = 12;
    localparam logic [7:0] IdValue = 8'hA5;

    logic       clk = 1'b0;
    logic       preset;
    logic       psel_a, psel_b, penable, pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata_a, prdata_b;
    logic       pready_a, pready_b, pslverr_a, pslverr_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] last_rd_a, last_rd_b;

    always #5 clk = ~clk;

    apb_completer_regfile dut_a (
        .pclk_i   (clk),
        .preset_i (preset),
        .psel_i   (psel_a),
        .penable_i(penable),
        .pwrite_i (pwrite),
        .paddr_i  (paddr),
        .pwdata_i (pwdata),
        .prdata_o (prdata_a),
        .pready_o (pready_a),
        .pslverr_o(pslverr_a)
    );

    apb_completer_regfile #(
        .DEPTH      (12),
        .WAIT_STATES(0),
        .ID_VALUE   (8'hA5)
    ) dut_b (
        .pclk_i   (clk),
        .preset_i (preset),
        .psel_i   (psel_b),
        .penable_i(penable),
        .pwrite_i (pwrite),
        .paddr_i  (paddr),
        .pwdata_i (pwdata),
        .prdata_o (prdata_b),
        .pready_o (pready_b),
        .pslverr_o(pslverr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        last_rd_a = 8'h00;
        last_rd_b = 8'h00;
    endtask

    // Full transfer on instance a (b=0, 2 wait states) or b (b=1, no wait states).
    task automatic xfer(input bit b, input bit w, input logic [3:0] a, input logic [7:0] d,
                        input string tag);
        int         cyc;
        int         ws;
        bit         exp_err;
        logic [7:0] exp_rd;
        logic [7:0] cur;
        ws      = b ? 0 : 2;
        exp_err = (int'(a) >= Depth) || (w && a == 4'd0);
        cur     = b ? mem_b[a] : mem_a[a];
        if (w) exp_rd = b ? last_rd_b : last_rd_a;
        else if (a == 4'd0) exp_rd = IdValue;
        else if (int'(a) >= Depth) exp_rd = 8'h00;
        else exp_rd = cur;

        if (b) psel_b = 1'b1;
        else psel_a = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
        @(posedge clk);
        #1;
        // Bus contents after setup must not matter.
        penable = 1'b1;
        pwrite  = 1'($urandom);
        paddr   = 4'($urandom);
        pwdata  = 8'($urandom);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(b ? pready_b : pready_a) && cyc < 40);
        check({tag, " latency"}, 32'(cyc), 32'(ws + 1));
        check({tag, " pslverr"}, 32'(b ? pslverr_b : pslverr_a), 32'(exp_err));
        check({tag, " prdata"}, 32'(b ? prdata_b : prdata_a), 32'(exp_rd));

        if (w && !exp_err) begin
            if (b) mem_b[a] = d;
            else mem_a[a] = d;
        end
        if (b) last_rd_b = exp_rd;
        else last_rd_a = exp_rd;

        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " pready drop"}, 32'(b ? pready_b : pready_a), 32'd0);
        check({tag, " pslverr drop"}, 32'(b ? pslverr_b : pslverr_a), 32'd0);
    endtask

    initial begin
        preset  = 1'b1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 4'd0;
        pwdata  = 8'h00;
        model_reset();

        // Reset held for three edges while psel toggles.
        for (int i = 0; i < 3; i++) begin
            psel_a  = ~psel_a;
            penable = 1'(i);
            @(posedge clk);
            #1;
            check("reset pready", 32'(pready_a), 32'd0);
            check("reset pslverr", 32'(pslverr_a), 32'd0);
            check("reset prdata", 32'(prdata_a), 32'h00);
        end
        preset  = 1'b0;
        psel_a  = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        xfer(0, 0, 4'd5, 8'h00, "rd5 after reset");

        xfer(0, 1, 4'd3, 8'h3C, "wr3");
        xfer(0, 0, 4'd3, 8'h00, "rd3");

        for (int i = 1; i < Depth; i++) xfer(0, 1, 4'(i), 8'(5 * i), "sweep wr");
        for (int i = 1; i < Depth; i++) xfer(0, 0, 4'(i), 8'h00, "sweep rd");
        xfer(0, 0, 4'd0, 8'h00, "rd id");
        xfer(0, 1, 4'd0, 8'hFF, "wr id");
        xfer(0, 0, 4'd0, 8'h00, "rd id again");

        xfer(0, 1, 4'd12, 8'h77, "wr oor");
        for (int i = 1; i < Depth; i++) xfer(0, 0, 4'(i), 8'h00, "rd after oor");
        xfer(0, 0, 4'd15, 8'h00, "rd oor");
        xfer(0, 0, 4'd1, 8'h00, "legal after oor");

        // Abort: drop psel while still counting wait states.
        psel_a  = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 4'd2;
        pwdata  = 8'hEE;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        check("abort pready wait", 32'(pready_a), 32'd0);
        psel_a  = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort pready", 32'(pready_a), 32'd0);
        end
        xfer(0, 0, 4'd2, 8'h00, "rd2 after abort");

        // Reset during ACCESS, then psel/penable held high without a setup phase.
        psel_a  = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 4'd4;
        pwdata  = 8'h99;
        @(posedge clk);
        #1;
        penable = 1'b1;
        preset  = 1'b1;
        @(posedge clk);
        #1;
        preset = 1'b0;
        model_reset();
        check("midreset prdata", 32'(prdata_a), 32'h00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("no setup pready", 32'(pready_a), 32'd0);
        end
        psel_a  = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        xfer(0, 0, 4'd4, 8'h00, "rd4 after midreset");
        xfer(0, 0, 4'd3, 8'h00, "rd3 after midreset");

        for (int i = 0; i < 40; i++) begin
            xfer(0, 1'($urandom), 4'($urandom), 8'($urandom), "random");
        end

        xfer(1, 1, 4'd1, 8'h5A, "ws0 wr1");
        xfer(1, 1, 4'd2, 8'hC3, "ws0 wr2");
        xfer(1, 0, 4'd1, 8'h00, "ws0 rd1");
        xfer(1, 0, 4'd2, 8'h00, "ws0 rd2");
        xfer(1, 1, 4'd13, 8'h11, "ws0 wr oor");
        xfer(1, 0, 4'd0, 8'h00, "ws0 rd id");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_completer_regfile.md
# apb_completer_regfile

APB completer (slave end) for the 8-bit APB bus driven by the team's APB requester/multi-slave fabric. It decodes one transfer at a time and holds a small register file with a read-only ID register at address 0. Each access inserts a fixed, parameterised number of wait states, and out-of-range or illegal accesses are flagged with pslverr. The block is instantiated once per slave select line behind the fabric's decoder.

## Interface
- DEPTH, 12: number of addressable locations; address 0 is the ID register, 1..DEPTH-1 are read/write; legal range 2..16
- WAIT_STATES, 2: extra access-phase cycles before pready is raised; legal range 0..15
- ID_VALUE, 8'hA5: value returned on reads of address 0
- pclk  in  1  bus clock; all logic on rising edge
- preset  in  1  synchronous, active-high reset
- psel  in  1  slave select from fabric decoder
- penable  in  1  access-phase strobe
- pwrite  in  1  1 = write, 0 = read
- paddr  in  4  word address
- pwdata  in  8  write data
- prdata  out  8  read data, valid while pready=1
- pready  out  1  transfer complete, registered
- pslverr  out  1  error response, valid only while pready=1

## Operation
- States: IDLE, ACCESS, DONE. Held in a registered state variable.
- Reset (preset=1 at an edge): state<=IDLE, pready=0, pslverr=0, prdata=8'h00, wait counter=0, every R/W location=8'h00. Reset wins over any bus activity, including a transfer in ACCESS or DONE, which is then abandoned with no write.
- IDLE: if the block samples psel=1 and penable=0, it latches paddr, pwrite and pwdata, loads the counter with WAIT_STATES, and moves to ACCESS. If it samples psel=1 and penable=1 (no setup phase), the sample is ignored.
- ACCESS: if psel=0, the transfer is aborted: go to IDLE with no write and no pready. If psel=1, penable=1 and the counter is nonzero, decrement the counter. If psel=1, penable=1 and the counter is 0, complete:
  - pready<=1.
  - err = (addr >= DEPTH) or (write and addr == 0).
  - pslverr<=err.
  - Write without error: mem[addr]<=pwdata at this edge.
  - Read: prdata<=ID_VALUE if addr==0; 8'h00 if addr>=DEPTH; mem[addr] otherwise.
  - Move to DONE.
- DONE: pready=1 for exactly one cycle. At the next edge: pready<=0, pslverr<=0, state<=IDLE. prdata holds its value until the next read completion.
- An erroring write does not modify any location.
- Decode always uses the latched address, write flag and data. Changes on paddr, pwrite or pwdata after setup are ignored.

## Timing
- Let E0 be the edge that samples the setup phase.
- pready is high in the cycle after edge E0+WAIT_STATES+1. The requester samples completion at edge E0+WAIT_STATES+2.
- Total transfer is WAIT_STATES+3 cycles including setup. With WAIT_STATES=0 this is 3 cycles; with the default (2) it is 5 cycles.
- Write data becomes visible to a later read at the completion edge.
- Back-to-back transfers: a new setup may be sampled at the first edge in IDLE, which is the edge after DONE. Minimum spacing is one idle cycle after pready falls.
- pslverr and prdata change only at completion; outputs never glitch mid-access.

## Test plan
- Reset: hold preset=1 for 3 cycles with psel toggling -> pready=0, pslverr=0, prdata=00. A subsequent read of addr 5 returns 00.
- Write then read, default parameters: write addr 3 data 8'h3C -> pready high exactly 3 cycles after the first penable cycle, pslverr=0. Read addr 3 -> prdata=3C, pslverr=0.
- Sweep: write 5*i to addrs 1..11, then read them back -> each returns 5*i. Read addr 0 -> A5. Write 8'hFF to addr 0 -> pslverr=1, and a later read of addr 0 still returns A5.
- Out of range: write addr 12 data 8'h77 -> pslverr=1, no location changes. Read addr 15 -> prdata=00, pslverr=1. The next legal transfer completes with pslverr=0.
- Abort and reset mid-transfer: drop psel during ACCESS on a write to addr 2 -> no pready, addr 2 unchanged. Assert preset during ACCESS -> IDLE next cycle, no write.
- WAIT_STATES=0 instance: back-to-back writes to addrs 1 and 2 with one idle cycle between -> each completes in 3 cycles, both values read back correctly.
